// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_stream_reader                                             |
// | Purpose  : FIFO read-side consumer; credit-gated skid buffer to stream.   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_stream_reader #(
   parameter int p_WIDTH      = 8,
   parameter int p_RD_LATENCY = 1,
   localparam int lp_DEPTH    = p_RD_LATENCY + 2,
   localparam int lp_LVL_W    = $clog2(lp_DEPTH + 1)
) (
   input  logic                rdclk,
   input  logic                rdrst,
   input  logic                fifo_empty,
   input  logic [p_WIDTH-1:0]  fifo_rddata,
   output logic                fifo_rdena,
   output logic [p_WIDTH-1:0]  m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [lp_LVL_W-1:0] level
);

   localparam int lp_PTR_W = $clog2(lp_DEPTH);
   localparam int lp_SUM_W = lp_LVL_W + 1;

   logic [p_WIDTH-1:0]      mem_q [lp_DEPTH];
   logic [lp_PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [lp_PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [lp_LVL_W-1:0]     occ_q, occ_d;
   logic [lp_LVL_W-1:0]     inflight;
   logic [p_RD_LATENCY-1:0] fire_q, fire_d;
   logic                    fire;
   logic                    push;
   logic                    pop;

   function automatic logic [lp_PTR_W-1:0] ptr_inc(input logic [lp_PTR_W-1:0] p);
      return (p == lp_PTR_W'(lp_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < p_RD_LATENCY; i++) begin
         inflight = inflight + lp_LVL_W'(fire_q[i]);
      end
   end

   // Credit gate: a read is only issued if its word is guaranteed a slot.
   assign fifo_rdena = rdrst & ~fifo_empty &
                       ((lp_SUM_W'(occ_q) + lp_SUM_W'(inflight)) < lp_SUM_W'(lp_DEPTH));
   assign fire       = fifo_rdena & ~fifo_empty;
   assign push       = fire_q[p_RD_LATENCY-1];
   assign m_valid    = (occ_q != '0);
   assign pop        = m_valid & m_ready;
   assign m_data     = mem_q[rd_ptr_q];
   assign level      = occ_q;

   generate
      if (p_RD_LATENCY == 1) begin : g_pipe_single
         assign fire_d = fire;
      end else begin : g_pipe_multi
         assign fire_d = {fire_q[p_RD_LATENCY-2:0], fire};
      end
   endgenerate

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      occ_d = occ_q + lp_LVL_W'(push) - lp_LVL_W'(pop);
   end

   always_ff @(posedge rdclk) begin
      if (!rdrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         fire_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         fire_q   <= fire_d;
      end
   end

   // Storage needs no reset; a stray write during reset is never made visible.
   always_ff @(posedge rdclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= fifo_rddata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_stream_reader                                          |
// | Purpose  : Bench for fifo_stream_reader, L=1 and L=3 instances.           |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_stream_reader;

   logic       clk;
   logic [1:0] rstn, empty, ready, rdena, valid;
   logic [7:0] rddata [2];
   logic [7:0] mdata  [2];
   logic [1:0] lvl0;
   logic [2:0] lvl1;

   logic [1:0] nx_rstn, nx_ready, nx_gap;

   // FIFO contents, words in flight (data + landing cycle), words in buffer
   logic [7:0] src_mem [2][256];
   int         src_wr [2], src_rd [2];
   logic [7:0] fl_dat [2][16];
   int         fl_land[2][16];
   int         fl_hd  [2], fl_tl [2];
   logic [7:0] ob_dat [2][16];
   int         ob_hd  [2], ob_tl [2];
   int         delivered [2];
   int         cyc;
   int         n_err, n_chk;

   fifo_stream_reader #(.p_WIDTH(8), .p_RD_LATENCY(1)) u_dut0 (
      .rdclk(clk), .rdrst(rstn[0]), .fifo_empty(empty[0]), .fifo_rddata(rddata[0]),
      .fifo_rdena(rdena[0]), .m_data(mdata[0]), .m_valid(valid[0]),
      .m_ready(ready[0]), .level(lvl0));

   fifo_stream_reader #(.p_WIDTH(8), .p_RD_LATENCY(3)) u_dut1 (
      .rdclk(clk), .rdrst(rstn[1]), .fifo_empty(empty[1]), .fifo_rddata(rddata[1]),
      .fifo_rdena(rdena[1]), .m_data(mdata[1]), .m_valid(valid[1]),
      .m_ready(ready[1]), .level(lvl1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
      end
   endtask

   // Reference model and per-cycle compare
   int         m_L, m_D, m_lvl, m_infl;
   logic       m_ev, m_er, m_fire;
   logic [31:0] m_dl;
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_L = (k == 0) ? 1 : 3;
         m_D = m_L + 2;
         while (fl_tl[k] != fl_hd[k] && fl_land[k][fl_hd[k] % 16] <= cyc) begin
            ob_dat[k][ob_tl[k] % 16] = fl_dat[k][fl_hd[k] % 16];
            ob_tl[k]++;
            fl_hd[k]++;
         end
         m_lvl  = ob_tl[k] - ob_hd[k];
         m_infl = fl_tl[k] - fl_hd[k];
         m_ev   = (m_lvl != 0);
         m_er   = rstn[k] && !empty[k] && (m_lvl + m_infl < m_D);
         m_dl   = (k == 0) ? {30'd0, lvl0} : {29'd0, lvl1};
         chk("rdena", k, {31'd0, rdena[k]}, {31'd0, m_er});
         chk("valid", k, {31'd0, valid[k]}, {31'd0, m_ev});
         chk("level", k, m_dl, m_lvl);
         chk("credit", k, {31'd0, (int'(m_dl) + m_infl <= m_D)}, 32'd1);
         if (m_ev) begin
            chk("data", k, {24'd0, mdata[k]}, {24'd0, ob_dat[k][ob_hd[k] % 16]});
         end
         m_fire = rdena[k] & ~empty[k];
         if (!rstn[k]) begin
            fl_hd[k] = fl_tl[k];
            ob_hd[k] = ob_tl[k];
            if (m_fire === 1'b1) src_rd[k]++;
         end else begin
            if (m_ev && ready[k]) begin
               ob_hd[k]++;
               delivered[k]++;
            end
            if (m_fire === 1'b1) begin
               fl_dat[k][fl_tl[k] % 16]  = src_mem[k][src_rd[k] % 256];
               fl_land[k][fl_tl[k] % 16] = cyc + m_L + 1;
               fl_tl[k]++;
               src_rd[k]++;
            end
         end
      end
      cyc++;
   end

   // Apply inputs just after the edge; the caller samples 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         rstn[k]   = nx_rstn[k];
         ready[k]  = nx_ready[k];
         empty[k]  = (src_wr[k] == src_rd[k]) || nx_gap[k];
         rddata[k] = 8'($urandom);
         for (int i = fl_hd[k]; i < fl_tl[k]; i++) begin
            if (fl_land[k][i % 16] == cyc + 1) rddata[k] = fl_dat[k][i % 16];
         end
      end
      #1;
   endtask

   task automatic load(input int k, input logic [7:0] w);
      src_mem[k][src_wr[k] % 256] = w;
      src_wr[k]++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int         nfire, fc, nv, maxl, d0;
   logic [7:0] gd [16];
   int         gc [16];

   initial begin
      n_err = 0; n_chk = 0; cyc = 0;
      for (int k = 0; k < 2; k++) begin
         src_wr[k] = 0; src_rd[k] = 0; fl_hd[k] = 0; fl_tl[k] = 0;
         ob_hd[k] = 0; ob_tl[k] = 0; delivered[k] = 0;
         rddata[k] = 8'h00;
      end
      rstn = 2'b00; empty = 2'b11; ready = 2'b00;
      nx_rstn = 2'b00; nx_ready = 2'b00; nx_gap = 2'b00;
      repeat (2) tick();
      nx_rstn = 2'b11; nx_ready = 2'b11;
      tick();
      chk("reset_level0", 0, {30'd0, lvl0}, 0);
      chk("reset_valid1", 1, {31'd0, valid[1]}, 0);

      // Basic: three words, ready held high
      load(0, 8'h11); load(0, 8'h22); load(0, 8'h33);
      nfire = 0; fc = -1; nv = 0; maxl = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rdena[0] && !empty[0]) begin
            if (fc < 0) fc = i;
            nfire++;
         end
         if (valid[0]) begin
            if (nv < 16) begin gd[nv] = mdata[0]; gc[nv] = i; end
            nv++;
         end
         if (int'(lvl0) > maxl) maxl = int'(lvl0);
      end
      chk("basic_fires", 0, nfire, 3);
      chk("basic_count", 0, nv, 3);
      chk("basic_d0", 0, {24'd0, gd[0]}, 32'h11);
      chk("basic_d1", 0, {24'd0, gd[1]}, 32'h22);
      chk("basic_d2", 0, {24'd0, gd[2]}, 32'h33);
      chk("basic_latency", 0, gc[0] - fc, 2);
      chk("basic_b2b", 0, gc[2] - gc[0], 2);
      chk("basic_maxlvl", 0, {31'd0, maxl <= 2}, 1);

      // Backpressure: buffer fills to its depth, then drains back-to-back
      nx_ready[0] = 1'b0;
      for (int j = 0; j < 10; j++) load(0, 8'(8'hA0 + j));
      nfire = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rdena[0] && !empty[0]) nfire++;
      end
      chk("bp_fires", 0, nfire, 3);
      chk("bp_level", 0, {30'd0, lvl0}, 3);
      chk("bp_rdena", 0, {31'd0, rdena[0]}, 0);
      chk("bp_hold", 0, {24'd0, mdata[0]}, 32'hA0);
      nx_ready[0] = 1'b1;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (valid[0] && ready[0]) begin
            if (nv < 16) begin gd[nv] = mdata[0]; gc[nv] = i; end
            nv++;
         end
      end
      chk("bp_count", 0, nv, 10);
      for (int j = 0; j < 10; j++) chk("bp_order", 0, {24'd0, gd[j]}, 8'hA0 + j);
      chk("bp_b2b", 0, gc[9] - gc[0], 9);

      // Reset with reads in flight
      load(0, 8'h01); load(0, 8'h02); load(0, 8'h03);
      tick();
      tick();
      chk("rst_fire2", 0, {31'd0, rdena[0]}, 1);
      nx_rstn[0] = 1'b0;
      tick();
      chk("rst_rdena", 0, {31'd0, rdena[0]}, 0);
      nx_rstn[0] = 1'b1;
      tick();
      chk("rst_valid", 0, {31'd0, valid[0]}, 0);
      chk("rst_level", 0, {30'd0, lvl0}, 0);
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (valid[0] && ready[0]) begin
            if (nv < 16) gd[nv] = mdata[0];
            nv++;
         end
      end
      chk("rst_count", 0, nv, 1);
      chk("rst_next", 0, {24'd0, gd[0]}, 32'h03);

      // Empty gaps on both instances
      for (int k = 0; k < 2; k++) begin
         d0 = delivered[k];
         for (int j = 0; j < 12; j++) load(k, 8'($urandom));
         for (int i = 0; i < 60; i++) begin
            nx_gap[k] = ((i / 2) % 2) == 1;
            tick();
         end
         nx_gap[k] = 1'b0;
         tick();
         chk("gap_count", k, delivered[k] - d0, 12);
      end

      // Random ready on the L=3 instance
      d0 = delivered[1];
      for (int j = 0; j < 200; j++) load(1, 8'($urandom));
      for (int i = 0; i < 3000; i++) begin
         if (delivered[1] - d0 >= 200) break;
         nx_ready[1] = 1'($urandom_range(0, 1));
         tick();
      end
      chk("rand_count", 1, delivered[1] - d0, 200);
      nx_ready[1] = 1'b1;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer of the asynchronous FIFO, running in the read clock domain.
- Drives the FIFO's rdena and captures rddata, which returns a fixed number of cycles later (block-RAM read latency).
- Re-presents the data as a valid/ready stream with a small credit-controlled skid buffer.
- Sustains one word per cycle with no bubbles, and never lets downstream backpressure lose a word already in flight.

Parameters:
- p_WIDTH, 8, data bus width; must be >= 1 and equal to the FIFO p_WIDTH.
- p_RD_LATENCY, 1, cycles from an accepted read to valid fifo_rddata; legal range 1..4.
- Derived lp_DEPTH = p_RD_LATENCY + 2, the number of skid-buffer entries.
- Derived lp_LVL_W = $clog2(lp_DEPTH + 1).

Ports:
- rdclk  input  1  read-domain clock; all logic on posedge.
- rdrst  input  1  reset. One clock; reset is synchronous and active-low.
- fifo_empty  input  1  FIFO empty flag (read domain).
- fifo_rddata  input  p_WIDTH  FIFO read data; valid p_RD_LATENCY cycles after an accepted read.
- fifo_rdena  output  1  FIFO read enable.
- m_data  output  p_WIDTH  stream data; the head of the skid buffer.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from downstream.
- level  output  lp_LVL_W  number of words currently held in the skid buffer.

Behaviour:
- Accepted read: fire = fifo_rdena & ~fifo_empty.
- fifo_rdena = rdrst & ~fifo_empty & (occ + inflight < lp_DEPTH).
  - Combinational from registers and fifo_empty only; no path from m_ready.
  - occ is the buffer occupancy.
  - inflight is the popcount of a p_RD_LATENCY-bit shift register of fire bits.
- Fire pipe: bit 0 <= fire each cycle. When the last bit is 1, fifo_rddata is written into the buffer at that clock edge.
- Buffer: circular lp_DEPTH entries with write and read pointers; the pointers wrap modulo lp_DEPTH.
- Stream side:
  - m_valid = (occ != 0); m_data = entry at the read pointer (registered storage, no fall-through).
  - Pop when m_valid & m_ready.
  - m_data must stay stable while m_valid=1 and m_ready=0.
- occ update: occ_next = occ + push - pop. Simultaneous push and pop leaves occ unchanged; both pointers advance.
- level = occ.
- Latency: a fire in cycle t gives the word at m_valid/m_data from cycle t + p_RD_LATENCY + 1.
- Throughput: with m_ready held at 1 and the FIFO non-empty, exactly one word per cycle in steady state.
- Ordering: words leave in exactly FIFO order. No duplication or loss under any m_ready pattern.
- Credit invariant: occ + inflight <= lp_DEPTH always. Overflow of the buffer is impossible by construction; the bench asserts it.
- fifo_empty rising mid-stream: fifo_rdena drops in the same cycle. Words already in flight still land and are delivered.
- Reset (rdrst=0 at a posedge):
  - occ, pointers and fire pipe are cleared to 0; m_valid=0 and level=0 from the next cycle.
  - fifo_rdena=0 combinationally while rdrst=0.
  - Reads in flight at reset are discarded: their returning rddata is not pushed.
  - m_data after reset is don't-care.
- Deasserting reset: fifo_rdena may assert in the first cycle with rdrst=1.

Test Plan:
- Reset drop: FIFO non-empty with words 0x01..0x03, m_ready=1, W=8, L=1. Pulse rdrst low for 1 cycle while 2 reads are in flight -> m_valid=0 and level=0 after reset. Streaming then resumes with the next FIFO word and no duplicates.
- Basic, W=8, L=1: FIFO preloaded with 0x11,0x22,0x33 and m_ready=1 -> fifo_rdena high for 3 cycles. m_data = 0x11,0x22,0x33 on 3 consecutive cycles, starting 2 cycles after the first fire. level never exceeds 2.
- Backpressure: FIFO holds 10 words, m_ready=0 -> exactly lp_DEPTH=3 reads fire. level=3, fifo_rdena=0, m_data holds word 0. Raising m_ready then yields words 0..9 in order, back-to-back.
- Random ready: L=3, 200 random words, m_ready random at 50% -> output sequence equals input sequence. Credit invariant holds every cycle; occ+inflight <= 5.
- Empty gaps: FIFO empty toggles every 2 cycles, m_ready=1 -> fifo_rdena never asserts while fifo_empty=1. All words are delivered with latency exactly L+1 from their fire.
